maze_map_gen: RTL

- Generates a pseudo-random occupancy map of CELLS_X x CELLS_Y tiles from an LFSR and stores it.
- The tile renderer stage directly downstream reads each cell through a registered read port and paints the cell accordingly.
- A start/busy/done handshake drives each generation, so the game FSM can regenerate the level on demand.

---
 rtl/maze_map_gen_pkg.sv | 17 +
 rtl/maze_map_gen_lfsr16.sv | 36 +++
 rtl/maze_map_gen.sv | 120 ++++++++++++
 3 files changed

// File: rtl/maze_map_gen_pkg.sv
// Shared constants and types for the maze map generator and its LFSR.
package maze_map_gen_pkg;

  localparam int unsigned MAP_CELLS_X = 32;
  localparam int unsigned MAP_CELLS_Y = 24;
  localparam int unsigned CELL_SIZE = 32;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    StIdle,
    StGen,
    StDone
  } map_state_e;

endpackage

// File: rtl/maze_map_gen_lfsr16.sv
// 16-bit right-shifting Galois LFSR with seed load; a zero load value falls back to SEED.
module lfsr16
  import maze_map_gen_pkg::*;
#(
  parameter logic [15:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (load_val == '0) ? SEED : load_val;
    end else if (en) begin
      q_d = (q_q >> 1) ^ (q_q[0] ? LFSR_MASK : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/maze_map_gen.sv
// Pseudo-random occupancy map generator: bordered maze written in raster order from an LFSR,
// with a start/busy/done handshake and a registered single-cell read port.
module maze_map_gen
  import maze_map_gen_pkg::*;
#(
  parameter int unsigned CELLS_X = MAP_CELLS_X,
  parameter int unsigned CELLS_Y = MAP_CELLS_Y,
  parameter logic [15:0] SEED    = DEFAULT_SEED,
  parameter int unsigned DENSITY = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        gen_start,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  output logic        busy,
  output logic        gen_done,
  output logic [9:0]  wall_count,
  input  logic [4:0]  rd_x,
  input  logic [4:0]  rd_y,
  output logic        rd_wall
);

  localparam int unsigned XW = $clog2(CELLS_X);
  localparam int unsigned YW = $clog2(CELLS_Y);
  localparam logic [4:0] DENSITY_W = 5'(DENSITY);

  map_state_e state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [CELLS_Y-1:0][CELLS_X-1:0] map_q;
  logic busy_q, gen_done_q, rd_wall_q;
  logic [9:0] wall_count_q;
  logic [15:0] lfsr_q;
  logic unused_lfsr;
  logic border, spawn, cell_val, last_cell;

  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == StGen),
    .load    (seed_load && (state_q == StIdle)),
    .load_val(seed_in),
    .q       (lfsr_q)
  );

  assign unused_lfsr = ^lfsr_q[15:4];

  always_comb begin
    border    = (x_q == '0) || (x_q == XW'(CELLS_X - 1)) ||
                (y_q == '0) || (y_q == YW'(CELLS_Y - 1));
    spawn     = (x_q == XW'(1)) && (y_q == YW'(1));
    // Border beats spawn, spawn beats the random draw.
    cell_val  = border || (!spawn && ({1'b0, lfsr_q[3:0]} < DENSITY_W));
    last_cell = (x_q == XW'(CELLS_X - 1)) && (y_q == YW'(CELLS_Y - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      x_q          <= '0;
      y_q          <= '0;
      map_q        <= '0;
      busy_q       <= 1'b0;
      gen_done_q   <= 1'b0;
      wall_count_q <= '0;
    end else begin
      gen_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gen_start) begin
            state_q      <= StGen;
            busy_q       <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            wall_count_q <= '0;
          end
        end
        StGen: begin
          map_q[y_q][x_q] <= cell_val;
          if (cell_val) begin
            wall_count_q <= wall_count_q + 10'd1;
          end
          if (x_q == XW'(CELLS_X - 1)) begin
            x_q <= '0;
            y_q <= y_q + YW'(1);
          end else begin
            x_q <= x_q + XW'(1);
          end
          if (last_cell) begin
            state_q    <= StDone;
            busy_q     <= 1'b0;
            gen_done_q <= 1'b1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Reads outside the map look like solid wall to the renderer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_wall_q <= 1'b0;
    end else if ((32'(rd_y) >= CELLS_Y) || (32'(rd_x) >= CELLS_X)) begin
      rd_wall_q <= 1'b1;
    end else begin
      rd_wall_q <= map_q[rd_y][rd_x];
    end
  end

  assign busy       = busy_q;
  assign gen_done   = gen_done_q;
  assign wall_count = wall_count_q;
  assign rd_wall    = rd_wall_q;

endmodule
